tcbm_drive_link: RTL and testbench

// - Drive-side TCBM link engine; sits directly across the cable from the host-side 6523 port emulation.
// - The host port emulation drives these TCBM signals:
//   - port A: 8-bit data.
//   - port C7: DAV, host->drive.
// - This block drives these TCBM signals back to the host:
//   - port C6: ACK, drive->host.
//   - port B[1:0]: status.
// - Runs the DAV/ACK byte handshake, decodes transaction codes, and converts transfers to valid/ready byte streams for the SD-side controller.

---
 rtl/tcbm_pkg.sv | 34 +++
 rtl/tcbm_sync.sv | 27 ++
 rtl/tcbm_drive_link.sv | 187 ++++++++++++++++++
 tb/tb_tcbm_drive_link.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcbm_pkg.sv
// Shared definitions for the drive-side TCBM link: transaction codes, status codes,
// FSM state encoding and the code-to-target decoder.
package tcbm_pkg;

    localparam logic [7:0] TCBM_CMD = 8'h81;
    localparam logic [7:0] TCBM_WR  = 8'h82;
    localparam logic [7:0] TCBM_RD  = 8'h83;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BADCODE = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CODE_HOLD,
        S_RX_WAIT,
        S_RX_PUSH,
        S_RX_HOLD,
        S_TX_WAIT,
        S_TX_FETCH,
        S_TX_SETUP,
        S_TX_HOLD
    } state_t;

    // Unknown codes map to S_IDLE, which doubles as the "bad code" indication.
    function automatic state_t code_target(input logic [7:0] code);
        case (code)
            TCBM_CMD, TCBM_WR: return S_RX_WAIT;
            TCBM_RD:           return S_TX_WAIT;
            default:           return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tcbm_sync.sv
// Parameterised-width two-flop synchronizer with asynchronous active-high reset
// and a configurable reset value.
module tcbm_sync #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tcbm_drive_link.sv
// Drive-side TCBM link engine: DAV/ACK byte handshake, code decode, rx/tx byte streams.
// Optional stall timeout is enabled by defining TCBM_TIMEOUT_EN.
module tcbm_drive_link
    import tcbm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pa_i,
    output logic [7:0] pa_o,
    output logic       pa_oe,
    input  logic       dav_i,
    output logic       ack_o,
    output logic [1:0] st_o,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_is_cmd,
    input  logic       rx_ready,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic [1:0] tx_status,
    output logic       tx_ready,
    output logic       busy,
    output logic       err
);

    logic       dav_s;
    logic [7:0] pa_s;

    tcbm_sync #(.W(1), .RST_VAL(1'b1)) u_dav_sync (
        .clk   (clk),
        .reset (reset),
        .d     (dav_i),
        .q     (dav_s)
    );

    tcbm_sync #(.W(8), .RST_VAL(8'h00)) u_pa_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pa_i),
        .q     (pa_s)
    );

    state_t     state_q, state_d, tgt_q, tgt_d;
    logic       cmd_q, cmd_d;
    logic       ack_d, oe_d, rx_valid_d, rx_cmd_d, err_d;
    logic [1:0] st_d;
    logic [7:0] pa_d, rx_data_d;
    logic       timeout;

`ifdef TCBM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    assign timeout = (state_q != S_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE || state_d != state_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES > 0) && (CNT_W > 0);
`endif

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cmd_d      = cmd_q;
        ack_d      = ack_o;
        st_d       = st_o;
        pa_d       = pa_o;
        oe_d       = pa_oe;
        rx_valid_d = rx_valid;
        rx_data_d  = rx_data;
        rx_cmd_d   = rx_is_cmd;
        err_d      = 1'b0;
        tx_ready   = 1'b0;

        case (state_q)
            S_IDLE: if (!dav_s) begin
                ack_d   = 1'b0;
                tgt_d   = code_target(pa_s);
                cmd_d   = (pa_s == TCBM_CMD);
                state_d = S_CODE_HOLD;
                if (code_target(pa_s) == S_IDLE) begin
                    st_d  = ST_BADCODE;
                    err_d = 1'b1;
                end else begin
                    st_d  = ST_OK;
                end
            end
            S_CODE_HOLD: if (dav_s) begin
                ack_d   = 1'b1;
                state_d = tgt_q;
            end
            S_RX_WAIT: if (!dav_s) begin
                rx_data_d  = pa_s;
                rx_cmd_d   = cmd_q;
                rx_valid_d = 1'b1;
                state_d    = S_RX_PUSH;
            end
            // ACK stays released while the consumer stalls; that is the host's backpressure.
            S_RX_PUSH: if (rx_ready) begin
                rx_valid_d = 1'b0;
                ack_d      = 1'b0;
                state_d    = S_RX_HOLD;
            end
            S_RX_HOLD: if (dav_s) begin
                ack_d   = 1'b1;
                st_d    = ST_OK;
                state_d = S_IDLE;
            end
            S_TX_WAIT: if (!dav_s) begin
                state_d = S_TX_FETCH;
            end
            S_TX_FETCH: if (tx_valid) begin
                tx_ready = 1'b1;
                pa_d     = tx_data;
                st_d     = tx_status;
                oe_d     = 1'b1;
                state_d  = S_TX_SETUP;
            end
            S_TX_SETUP: begin
                ack_d   = 1'b0;
                state_d = S_TX_HOLD;
            end
            S_TX_HOLD: if (dav_s) begin
                ack_d   = 1'b1;
                oe_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A stall only counts while the state is not about to change on its own.
        if (timeout && state_d == state_q) begin
            state_d    = S_IDLE;
            ack_d      = 1'b1;
            oe_d       = 1'b0;
            rx_valid_d = 1'b0;
            st_d       = ST_TIMEOUT;
            err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tgt_q     <= S_IDLE;
            cmd_q     <= 1'b0;
            ack_o     <= 1'b1;
            st_o      <= ST_OK;
            pa_o      <= 8'h00;
            pa_oe     <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            rx_is_cmd <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cmd_q     <= cmd_d;
            ack_o     <= ack_d;
            st_o      <= st_d;
            pa_o      <= pa_d;
            pa_oe     <= oe_d;
            rx_valid  <= rx_valid_d;
            rx_data   <= rx_data_d;
            rx_is_cmd <= rx_cmd_d;
            err       <= err_d;
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_tcbm_drive_link.sv
// Self-checking bench for tcbm_drive_link: directed scenarios plus a randomized
// transaction mix checked against a queue-based host/consumer model.
module tb_tcbm_drive_link;

    logic       clk;
    logic       reset;
    logic [7:0] pa_i;
    logic [7:0] pa_o;
    logic       pa_oe;
    logic       dav_i;
    logic       ack_o;
    logic [1:0] st_o;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_is_cmd;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] tx_status;
    logic       tx_ready;
    logic       busy;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_ready = 1'b0;

    tcbm_drive_link #(.TIMEOUT_CYCLES(100), .CNT_W(17)) dut (
        .clk       (clk),
        .reset     (reset),
        .pa_i      (pa_i),
        .pa_o      (pa_o),
        .pa_oe     (pa_oe),
        .dav_i     (dav_i),
        .ack_o     (ack_o),
        .st_o      (st_o),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_is_cmd (rx_is_cmd),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_status (tx_status),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive monitor: everything it records is sampled mid-cycle.
    logic [8:0] got_q[$];
    int   err_seen    = 0;
    int   txr_seen    = 0;
    int   rxv_cycles  = 0;
    int   ack_falls   = 0;
    int   overlap     = 0;
    logic ack_prev    = 1'b1;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back({rx_is_cmd, rx_data});
        if (err) err_seen++;
        if (tx_ready) txr_seen++;
        if (rx_valid) rxv_cycles++;
        if (pa_oe && rx_valid) overlap++;
        if (ack_prev && !ack_o) ack_falls++;
        ack_prev = ack_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_ack(input logic lvl, input int budget, input string what, output int cycles);
        cycles = 0;
        while (ack_o !== lvl && cycles < budget) begin
            tick();
            cycles++;
            if (rand_ready) rx_ready = ($urandom_range(0, 1) == 1);
        end
        if (ack_o !== lvl) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: ack_o=%b after %0d clk, wanted %b", what, ack_o, cycles, lvl);
        end
    endtask

    task automatic host_code(input logic [7:0] code, output int lat);
        int c;
        pa_i = code;
        tick();
        dav_i = 1'b0;
        wait_ack(1'b0, 20, "code_ack", lat);
        dav_i = 1'b1;
        wait_ack(1'b1, 20, "code_release", c);
    endtask

    task automatic host_write(input logic [7:0] b, input int budget);
        int c;
        pa_i = b;
        tick();
        dav_i = 1'b0;
        wait_ack(1'b0, budget, "write_ack", c);
        dav_i = 1'b1;
        wait_ack(1'b1, 20, "write_release", c);
    endtask

    task automatic host_read(output logic [7:0] d, output logic [1:0] s, output logic oe);
        int c;
        dav_i = 1'b0;
        wait_ack(1'b0, 50, "read_ack", c);
        d  = pa_o;
        s  = st_o;
        oe = pa_oe;
        dav_i = 1'b1;
        wait_ack(1'b1, 20, "read_release", c);
    endtask

    task automatic test_reset();
        logic [24:0] obs, exp_v;
        reset = 1'b1; dav_i = 1'b1; pa_i = 8'h00; rx_ready = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; tx_status = 2'b00;
        tick();
        tick();
        exp_v = {8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        obs   = {pa_o, pa_oe, ack_o, st_o, rx_valid, rx_data, rx_is_cmd, tx_ready, busy, err, 1'b0};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs, exp_v);
        end
        reset = 1'b0;
        tick();
        tick();
        n_tests++;
        if (busy !== 1'b0 || ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b ack_o=%b expected 0/1", busy, ack_o);
        end
    endtask

    task automatic test_cmd_byte();
        int lat, n0, af0, rv0;
        n0 = got_q.size(); af0 = ack_falls; rv0 = rxv_cycles;
        rx_ready = 1'b1;
        host_code(8'h81, lat);
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL code_latency: got %0d clk expected 3", lat);
        end
        host_write(8'h55, 50);
        tick();
        n_tests++;
        if (got_q.size() !== n0 + 1 || got_q[got_q.size()-1] !== {1'b1, 8'h55}) begin
            n_fail++;
            $display("FAIL cmd_rx: got %0d bytes last=%h expected 1 byte 155", got_q.size() - n0,
                     got_q.size() > 0 ? got_q[got_q.size()-1] : 9'h0);
        end
        n_tests++;
        if (rxv_cycles - rv0 !== 1) begin
            n_fail++;
            $display("FAIL cmd_rx_valid_width: got %0d clk expected 1", rxv_cycles - rv0);
        end
        n_tests++;
        if (ack_falls - af0 !== 2) begin
            n_fail++;
            $display("FAIL cmd_ack_count: got %0d expected 2", ack_falls - af0);
        end
        n_tests++;
        if (st_o !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cmd_end: st_o=%b busy=%b expected 00/0", st_o, busy);
        end
    endtask

    task automatic test_read();
        int lat, oe_at, ack_at, t0;
        oe_at = -1; ack_at = -1; t0 = txr_seen;
        tx_valid = 1'b1; tx_data = 8'hA7; tx_status = 2'b01;
        host_code(8'h83, lat);
        dav_i = 1'b0;
        for (int i = 1; i <= 30 && ack_at < 0; i++) begin
            tick();
            if (pa_oe === 1'b1 && oe_at < 0) oe_at = i;
            if (ack_o === 1'b0) ack_at = i;
        end
        n_tests++;
        if (ack_at < 0 || oe_at < 0 || ack_at - oe_at !== 1) begin
            n_fail++;
            $display("FAIL read_setup: pa_oe at %0d ack_o low at %0d expected 1 clk apart", oe_at, ack_at);
        end
        n_tests++;
        if (pa_o !== 8'hA7 || pa_oe !== 1'b1 || st_o !== 2'b01) begin
            n_fail++;
            $display("FAIL read_data: pa_o=%h pa_oe=%b st_o=%b expected a7/1/01", pa_o, pa_oe, st_o);
        end
        tx_valid = 1'b0;
        dav_i = 1'b1;
        wait_ack(1'b1, 20, "read_release", lat);
        n_tests++;
        if (pa_oe !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_release: pa_oe=%b busy=%b expected 0/0", pa_oe, busy);
        end
        tick();
        n_tests++;
        if (txr_seen - t0 !== 1 || st_o !== 2'b01) begin
            n_fail++;
            $display("FAIL read_handshake: tx_ready pulses=%0d st_o=%b expected 1/01", txr_seen - t0, st_o);
        end
    endtask

    task automatic test_backpressure();
        int lat, bad_ack, bad_rx, n0;
        bad_ack = 0; bad_rx = 0; n0 = got_q.size();
        rx_ready = 1'b0;
        host_code(8'h82, lat);
        pa_i = 8'h3C;
        tick();
        dav_i = 1'b0;
        for (int i = 0; i < 20 && rx_valid !== 1'b1; i++) tick();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ack_o !== 1'b1) bad_ack++;
            if (rx_valid !== 1'b1 || rx_data !== 8'h3C || rx_is_cmd !== 1'b0) bad_rx++;
        end
        n_tests++;
        if (bad_ack !== 0) begin
            n_fail++;
            $display("FAIL bp_ack_held: ack_o low in %0d of 50 stalled clk, expected 0", bad_ack);
        end
        n_tests++;
        if (bad_rx !== 0) begin
            n_fail++;
            $display("FAIL bp_rx_stable: rx not 3c/valid in %0d of 50 clk, expected 0", bad_rx);
        end
        rx_ready = 1'b1;
        tick();
        n_tests++;
        if (ack_o !== 1'b0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: ack_o=%b rx_valid=%b 1 clk after accept, expected 0/0", ack_o, rx_valid);
        end
        dav_i = 1'b1;
        wait_ack(1'b1, 20, "bp_release", lat);
        n_tests++;
        if (got_q.size() !== n0 + 1 || got_q[got_q.size()-1] !== {1'b0, 8'h3C} || st_o !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_byte: got %0d bytes st_o=%b expected 1 byte 03c st 00", got_q.size() - n0, st_o);
        end
    endtask

    task automatic test_bad_code();
        int c, e0, n0;
        e0 = err_seen; n0 = got_q.size();
        pa_i = 8'h90;
        tick();
        dav_i = 1'b0;
        wait_ack(1'b0, 20, "bad_ack", c);
        n_tests++;
        if (st_o !== 2'b11) begin
            n_fail++;
            $display("FAIL bad_status: st_o=%b expected 11", st_o);
        end
        dav_i = 1'b1;
        wait_ack(1'b1, 20, "bad_release", c);
        tick();
        n_tests++;
        if (err_seen - e0 !== 1 || busy !== 1'b0 || got_q.size() !== n0 || st_o !== 2'b11) begin
            n_fail++;
            $display("FAIL bad_end: err pulses=%0d busy=%b rx bytes=%0d st_o=%b expected 1/0/0/11",
                     err_seen - e0, busy, got_q.size() - n0, st_o);
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_q[$];
        logic [7:0] b, code, d;
        logic [1:0] s, rs;
        logic       oe;
        int kind, lat, n0, e0, t0, exp_err, exp_rd;
        n0 = got_q.size(); e0 = err_seen; t0 = txr_seen; exp_err = 0; exp_rd = 0;
        rand_ready = 1'b1;
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 3);
            b    = 8'($urandom);
            case (kind)
                0, 1: begin
                    exp_q.push_back({kind == 0, b});
                    host_code(kind == 0 ? 8'h81 : 8'h82, lat);
                    host_write(b, 400);
                    n_tests++;
                    if (st_o !== 2'b00 || busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand_rx_end[%0d]: st_o=%b busy=%b expected 00/0", it, st_o, busy);
                    end
                end
                2: begin
                    rs = 2'($urandom);
                    tx_data = b; tx_status = rs; tx_valid = 1'b1;
                    exp_rd++;
                    host_code(8'h83, lat);
                    host_read(d, s, oe);
                    tx_valid = 1'b0;
                    n_tests++;
                    if (d !== b || s !== rs || oe !== 1'b1 || pa_oe !== 1'b0 || st_o !== rs) begin
                        n_fail++;
                        $display("FAIL rand_read[%0d]: pa_o=%h st=%b oe=%b/%b expected %h %b 1/0",
                                 it, d, s, oe, pa_oe, b, rs);
                    end
                end
                default: begin
                    code = 8'($urandom);
                    if (code >= 8'h81 && code <= 8'h83) code = code ^ 8'h40;
                    exp_err++;
                    host_code(code, lat);
                    n_tests++;
                    if (st_o !== 2'b11 || busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand_bad[%0d]: code %h st_o=%b busy=%b expected 11/0", it, code, st_o, busy);
                    end
                end
            endcase
        end
        rand_ready = 1'b0;
        rx_ready = 1'b1;
        tick();
        n_tests++;
        if (got_q.size() - n0 !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_rx_count: got %0d expected %0d", got_q.size() - n0, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_tests++;
                if (got_q[n0 + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_rx_byte[%0d]: got %h expected %h", i, got_q[n0 + i], exp_q[i]);
                end
            end
        end
        n_tests++;
        if (err_seen - e0 !== exp_err || txr_seen - t0 !== exp_rd) begin
            n_fail++;
            $display("FAIL rand_pulses: err=%0d tx_ready=%0d expected %0d/%0d",
                     err_seen - e0, txr_seen - t0, exp_err, exp_rd);
        end
    endtask

    task automatic test_timeout();
        int lat, cyc;
        tx_valid = 1'b0;
        host_code(8'h83, lat);
        dav_i = 1'b0;
`ifdef TCBM_TIMEOUT_EN
        cyc = 0;
        while (err !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc < 100 || cyc > 106) begin
            n_fail++;
            $display("FAIL timeout_time: err after %0d clk expected about 100", cyc);
        end
        n_tests++;
        if (err !== 1'b1 || st_o !== 2'b10 || ack_o !== 1'b1 || busy !== 1'b0 || pa_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: err=%b st_o=%b ack_o=%b busy=%b pa_oe=%b expected 1/10/1/0/0",
                     err, st_o, ack_o, busy, pa_oe);
        end
`else
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (busy !== 1'b1 || ack_o !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout: after %0d clk busy=%b ack_o=%b err=%b expected 1/1/0", cyc, busy, ack_o, err);
        end
`endif
        dav_i = 1'b1;
        do_reset();
    endtask

    task automatic test_reset_tx_hold();
        int lat, c, n0;
        tx_valid = 1'b1; tx_data = 8'h5A; tx_status = 2'b00;
        host_code(8'h83, lat);
        dav_i = 1'b0;
        wait_ack(1'b0, 50, "hold_ack", c);
        n_tests++;
        if (pa_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_reached: pa_oe=%b expected 1", pa_oe);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (ack_o !== 1'b1 || pa_oe !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: ack_o=%b pa_oe=%b busy=%b expected 1/0/0", ack_o, pa_oe, busy);
        end
        dav_i = 1'b1;
        tx_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n0 = got_q.size();
        rx_ready = 1'b1;
        host_code(8'h81, lat);
        host_write(8'hC3, 50);
        tick();
        n_tests++;
        if (got_q.size() !== n0 + 1 || got_q[got_q.size()-1] !== {1'b1, 8'hC3} || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_xfer: got %0d bytes busy=%b expected 1 byte 1c3 busy 0",
                     got_q.size() - n0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_byte();
        test_read();
        test_backpressure();
        test_bad_code();
        test_random();
        test_timeout();
        test_reset_tx_hold();
        n_tests++;
        if (overlap !== 0) begin
            n_fail++;
            $display("FAIL oe_rx_overlap: %0d clk with pa_oe and rx_valid both set, expected 0", overlap);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule
